// File: rtl/hidden_layer_sequencer.sv
// -----------------------------------------------------------------------------
// hidden_layer_sequencer
//
// Time-multiplexes one shared node instance across every neuron of the hidden
// layer. For each neuron index it holds the node's start high, waits for the
// node's level ready, captures the node output through a ReLU into the layer
// buffer, and tracks a running argmax. When all neurons are stored the packed
// layer vector plus argmax is held for the output-layer stage.
//
// Ports:
//   i_clock        rising-edge clock
//   i_reset_n      synchronous active-low reset
//   i_start        start a new layer pass (honoured only in IDLE or DONE)
//   i_node_ready   node result valid (level)
//   i_node_out     node result, signed Q(bits-fractional_bits-1).fractional_bits
//   o_node_start   start/enable to the node; a low cycle aborts/rearms it
//   o_node_index   neuron currently being evaluated (weight row / bias select)
//   o_busy         pass in progress (LAUNCH, WAIT, STORE)
//   o_done         pass complete, outputs valid
//   o_layer_out    packed activations, neuron k at [k*bits +: bits]
//   o_max_index    index of the largest activation (lowest index on ties)
//   o_max_value    largest activation
// -----------------------------------------------------------------------------
module hidden_layer_sequencer #(
    parameter int bits            = 16,
    parameter int fractional_bits = 11,
    parameter int layer_size      = 50,
    parameter int idx_bits        = $clog2(layer_size)
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic                         i_start,
    input  logic                         i_node_ready,
    input  logic signed [bits-1:0]       i_node_out,
    output logic                         o_node_start,
    output logic [idx_bits-1:0]          o_node_index,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [layer_size*bits-1:0]   o_layer_out,
    output logic [idx_bits-1:0]          o_max_index,
    output logic signed [bits-1:0]       o_max_value
);

    // The fixed-point format is only carried through; reject nonsense at
    // elaboration so a bad parameterisation cannot slip by silently.
    if (fractional_bits < 0 || fractional_bits >= bits) begin : g_bad_format
        $error("fractional_bits must be in [0, bits-1]");
    end

    localparam logic [idx_bits-1:0] LAST_IDX = idx_bits'(layer_size - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [idx_bits-1:0]          r_idx;
    logic [layer_size*bits-1:0]   r_layer;
    logic [idx_bits-1:0]          r_max_idx;
    logic signed [bits-1:0]       r_max_val;

    logic                         w_new_pass;
    logic                         w_capture;
    logic signed [bits-1:0]       w_act;

    // ReLU: negative results clamp to zero, everything else passes bit-exact.
    assign w_act = i_node_out[bits-1] ? '0 : i_node_out;

    always_comb begin
        w_next       = r_state;
        o_node_start = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        w_new_pass   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_new_pass = 1'b1;
                    w_next     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                o_node_start = 1'b1;
                o_busy       = 1'b1;
                // A ready still high here belongs to the previous neuron;
                // hold until it drops so it is never captured.
                if (!i_node_ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                o_node_start = 1'b1;
                o_busy       = 1'b1;
                if (i_node_ready) begin
                    w_capture = 1'b1;
                    w_next    = S_STORE;
                end
            end
            S_STORE: begin
                o_busy = 1'b1;
                w_next = (r_idx == LAST_IDX) ? S_DONE : S_LAUNCH;
            end
            S_DONE: begin
                o_done = 1'b1;
                if (i_start) begin
                    w_new_pass = 1'b1;
                    w_next     = S_LAUNCH;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_layer   <= '0;
            r_max_idx <= '0;
            r_max_val <= '0;
        end else begin
            r_state <= w_next;
            if (w_new_pass) begin
                r_idx     <= '0;
                r_max_idx <= '0;
                r_max_val <= '0;
            end
            if (w_capture) begin
                r_layer[r_idx*bits +: bits] <= w_act;
                // Strict compare keeps the lowest index on ties; neuron 0
                // always seeds the running maximum.
                if (r_idx == '0 || w_act > r_max_val) begin
                    r_max_val <= w_act;
                    r_max_idx <= r_idx;
                end
            end
            if (r_state == S_STORE && r_idx != LAST_IDX)
                r_idx <= r_idx + 1'b1;
        end
    end

    assign o_node_index = r_idx;
    assign o_layer_out  = r_layer;
    assign o_max_index  = r_max_idx;
    assign o_max_value  = r_max_val;

endmodule

// File: tb/tb_hidden_layer_sequencer.sv
module tb_hidden_layer_sequencer;

    localparam int BITS = 16;
    localparam int LS   = 4;
    localparam int IB   = 2;
    localparam int LAT  = 3;

    logic                      clock = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      start = 1'b0;
    logic                      node_ready = 1'b0;
    logic signed [BITS-1:0]    node_out = '0;
    logic                      node_start;
    logic [IB-1:0]             node_index;
    logic                      busy;
    logic                      done;
    logic [LS*BITS-1:0]        layer_out;
    logic [IB-1:0]             max_index;
    logic signed [BITS-1:0]    max_value;

    int total = 0;
    int bad   = 0;

    hidden_layer_sequencer #(
        .bits(BITS), .fractional_bits(11), .layer_size(LS)
    ) dut (
        .i_clock(clock), .i_reset_n(reset_n), .i_start(start),
        .i_node_ready(node_ready), .i_node_out(node_out),
        .o_node_start(node_start), .o_node_index(node_index),
        .o_busy(busy), .o_done(done), .o_layer_out(layer_out),
        .o_max_index(max_index), .o_max_value(max_value)
    );

    always #5 clock = ~clock;

    // Behavioural node: counts LAT cycles with start high, then raises ready
    // and keeps it high for hold_cfg extra cycles regardless of start.
    logic signed [BITS-1:0] vals [LS];
    int cnt = LAT;
    int hold_left = 0;
    int hold_cfg = 0;

    always @(posedge clock) begin
        if (node_ready) begin
            if (hold_left > 0) hold_left <= hold_left - 1;
            else begin
                node_ready <= 1'b0;
                cnt        <= LAT;
            end
        end else if (!node_start) begin
            cnt <= LAT;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end else begin
            node_ready <= 1'b1;
            node_out   <= vals[node_index];
            hold_left  <= hold_cfg;
        end
    end

    // Monitor: index presented at each node_start rise, and length of each
    // low gap between neurons inside a pass.
    int idx_q[$];
    int gap_q[$];
    int gap = 0;
    logic prev_ns = 1'b0;

    always @(negedge clock) begin
        if (node_start && !prev_ns) begin
            idx_q.push_back(int'(node_index));
            if (gap > 0) gap_q.push_back(gap);
            gap = 0;
        end else if (!node_start && busy) begin
            gap++;
        end
        prev_ns = node_start;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_vals(input logic [15:0] v0, input logic [15:0] v1,
                            input logic [15:0] v2, input logic [15:0] v3);
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    endtask

    // Launch a pass; optionally poke start mid-pass (must be ignored).
    task automatic run_pass(input string tag, input bit poke);
        idx_q.delete();
        gap_q.delete();
        gap = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_start_lat"}, 64'(node_start), 64'd1);
        if (poke) begin
            repeat (7) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int i = 0; i < 400 && !done; i++) tick();
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_idx_cnt"}, 64'(idx_q.size()), 64'd4);
        for (int k = 0; k < idx_q.size() && k < 4; k++)
            check($sformatf("%s_idx%0d", tag, k), 64'(idx_q[k]), 64'(k));
        check({tag, "_gap_cnt"}, 64'(gap_q.size()), 64'd3);
        for (int k = 0; k < gap_q.size(); k++)
            check($sformatf("%s_gap%0d", tag, k), 64'(gap_q[k]), 64'd1);
    endtask

    initial begin
        set_vals(16'h0800, 16'hF800, 16'h0C00, 16'h0400);

        // Reset
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("rst_node_start", 64'(node_start), 64'd0);
        check("rst_node_index", 64'(node_index), 64'd0);
        check("rst_busy",       64'(busy), 64'd0);
        check("rst_done",       64'(done), 64'd0);
        check("rst_layer",      64'(layer_out), 64'd0);
        check("rst_max_idx",    64'(max_index), 64'd0);
        check("rst_max_val",    64'(max_value), 64'd0);
        repeat (3) tick();
        check("idle_no_start",  64'(node_start), 64'd0);

        // Basic pass with one negative output
        hold_cfg = 0;
        run_pass("p1", 1'b0);
        check("p1_layer",   64'(layer_out), 64'h0400_0C00_0000_0800);
        check("p1_max_idx", 64'(max_index), 64'd2);
        check("p1_max_val", 64'(max_value), 64'h0C00);
        repeat (3) tick();
        check("p1_hold_done", 64'(done), 64'd1);
        check("p1_hold_ns",   64'(node_start), 64'd0);

        // Tie case, stale ready held 3 extra cycles, stray start mid-pass
        set_vals(16'h0200, 16'h0200, 16'h0100, 16'h0000);
        hold_cfg = 3;
        run_pass("p2", 1'b1);
        check("p2_layer",   64'(layer_out), 64'h0000_0100_0200_0200);
        check("p2_max_idx", 64'(max_index), 64'd0);
        check("p2_max_val", 64'(max_value), 64'h0200);
        for (int i = 0; i < 20 && node_ready; i++) tick();

        // All negative
        set_vals(16'h8000, 16'hFFFF, 16'hF800, 16'hC000);
        hold_cfg = 0;
        run_pass("p3", 1'b0);
        check("p3_layer",   64'(layer_out), 64'd0);
        check("p3_max_idx", 64'(max_index), 64'd0);
        check("p3_max_val", 64'(max_value), 64'd0);

        // Reset while waiting on neuron 2
        set_vals(16'h0800, 16'hF800, 16'h0C00, 16'h0400);
        run_pass("p4", 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && node_index != 2'd2; i++) tick();
        check("mid_reach_idx2", 64'(node_index), 64'd2);
        tick();
        check("mid_in_wait_ns", 64'(node_start), 64'd1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_ns",    64'(node_start), 64'd0);
        check("mid_rst_busy",  64'(busy), 64'd0);
        check("mid_rst_layer", 64'(layer_out), 64'd0);
        check("mid_rst_done",  64'(done), 64'd0);
        check("mid_rst_idx",   64'(node_index), 64'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 20 && node_ready; i++) tick();
        tick();
        run_pass("p5", 1'b0);
        check("p5_layer",   64'(layer_out), 64'h0400_0C00_0000_0800);
        check("p5_max_idx", 64'(max_index), 64'd2);
        check("p5_max_val", 64'(max_value), 64'h0C00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hidden_layer_sequencer.md
# hidden_layer_sequencer

Control stage that time-multiplexes one shared `node` instance (bits=16, fractional_bits=11, in_size=784) across all neurons of the hidden layer. It steps through neuron indices, starts the node once per neuron, and waits for the node's level `ready`. It then captures the node's `out`, applies ReLU, and stores the result in a layer buffer. When every neuron is done it presents the whole layer as one packed vector, with a running argmax, to the output-layer stage.

## Interface
Parameters:
- `bits`, 16: word width of node outputs and stored activations (signed fixed point).
- `fractional_bits`, 11: fractional bits of the format. Carried through only; no rescaling occurs in this block.
- `layer_size`, 50: number of neurons to sequence.
- `idx_bits`, `$clog2(layer_size)`: width of neuron index outputs.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `start`  in  1: request a new layer pass. Sampled only in IDLE or DONE.
- `node_ready`  in  1: the node's `ready` (level; high while its result is valid).
- `node_out`  in  signed `bits`: the node's `out`.
- `node_start`  out  1: drives the node's `start`.
- `node_index`  out  `idx_bits`: selects the weight row and bias for the node (`weights[node_index*784 +: 784]`, `bias[node_index]`).
- `busy`  out  1: high in LAUNCH, WAIT and STORE.
- `done`  out  1: high in DONE; cleared when a new pass starts.
- `layer_out`  out  `layer_size*bits`: packed activations. Neuron k is at `[k*bits +: bits]`.
- `max_index`  out  `idx_bits`: index of the largest activation.
- `max_value`  out  signed `bits`: value of the largest activation.

## Operation
- States are IDLE, LAUNCH, WAIT, STORE and DONE. Reset enters IDLE.
- IDLE or DONE with `start`=1:
  - Clear `idx` to 0.
  - Clear `max_index` and `max_value` to 0.
  - Go to LAUNCH. `layer_out` is not cleared; entries are overwritten as the pass proceeds.
- LAUNCH:
  - Drive `node_start`=1 and `node_index`=`idx`.
  - Wait until `node_ready`=0 (a stale ready from the previous neuron must have dropped), then go to WAIT.
- WAIT:
  - `node_start` stays 1.
  - When `node_ready`=1, register `act = (node_out < 0) ? 0 : node_out` into `layer_out[idx]` and go to STORE.
- Argmax update, on the same edge as the capture:
  - If `idx`==0, or `act` > `max_value` (strict), load `max_value`=`act` and `max_index`=`idx`.
  - On ties the lowest index wins.
- STORE:
  - `node_start`=0 for exactly one cycle.
  - If `idx`==`layer_size`-1, go to DONE. Otherwise increment `idx` and go to LAUNCH.
- DONE: `node_start`=0. Hold all outputs until the next `start`.
- Arithmetic: ReLU is the only transform. The stored value is bit-identical to `node_out` when non-negative, otherwise 0. Format stays Q(`bits`-`fractional_bits`-1).`fractional_bits`.

## Timing
- Reset values:
  - `node_start`=0, `node_index`=0, `busy`=0, `done`=0.
  - `layer_out`=0 (all entries), `max_index`=0, `max_value`=0.
- Reset mid-pass:
  - Returns to IDLE on the next edge and applies all reset values.
  - `node_start` drops in that same edge, which aborts the node.
- Latency:
  - `start` sampled at edge t gives `node_start`=1 from t+1.
  - `node_ready` seen high at edge r gives the capture plus `node_start`=0 at r+1, then LAUNCH for the next neuron at r+2.
  - Per-neuron overhead is 2 cycles plus the node's compute time.
- `done` rises on the edge after the last STORE cycle.
- `start` while `busy` is ignored.
- `start` held high in DONE restarts a pass immediately.
- `node_ready` already high on entry to LAUNCH: stay in LAUNCH with `node_start`=1 until it falls. Never capture a stale result.
- `idx` never exceeds `layer_size`-1; there is no wrap.

## Test plan
- Reset with `reset_n`=0 for 2 cycles, then release -> all outputs 0, state IDLE, and `node_start` stays 0 without `start`.
- `layer_size`=4, behavioural node returns 0x0800, 0xF800, 0x0C00, 0x0400 for neurons 0-3 -> `layer_out` = {0x0400, 0x0C00, 0x0000, 0x0800} (k=3..0), `max_index`=2, `max_value`=0x0C00, `done`=1.
- Tie case: outputs 0x0200, 0x0200, 0x0100, 0x0000 -> `max_index`=0.
- All outputs negative -> every entry is 0, `max_index`=0, `max_value`=0.
- Check per neuron:
  - `node_start` falls for exactly 1 cycle between neurons.
  - `node_index` increments 0→1→2→3.
  - `node_ready` still high at relaunch delays WAIT until it falls.
- Assert `reset_n`=0 while in WAIT for neuron 2 -> next cycle has `node_start`=0, `busy`=0 and `layer_out`=0. A following `start` runs a complete correct pass.
